// File: rtl/ddmtd_dco.sv
// rtl/ddmtd_dco.sv - DDMTD helper DCO: PI loop filter, lock/holdover FSM and phase accumulator
// The synthesised feedback clock is the accumulator MSB; the loop steers its FCW from beat phase errors.
module ddmtd_dco #(
   parameter int COUNT_W    = 16,
   parameter int ACC_W      = 24,
   parameter int KP_SHIFT   = 4,
   parameter int KI_SHIFT   = 0,
   parameter int HELPER_DIV = 1000,
   parameter int LOCK_TOL   = 2,
   parameter int LOCK_CNT   = 8,
   parameter int TIMEOUT    = 4096
) (
   input  logic                      clk_sys,
   input  logic                      rst_n,
   input  logic                      ena,
   input  logic [ACC_W-1:0]          fcw_nom,
   input  logic                      phase_valid,
   input  logic signed [COUNT_W-1:0] phase_err_beat,
   output logic                      helper_tick,
   output logic                      clk_fb_out,
   output logic [ACC_W-1:0]          fcw_cur,
   output logic                      locked,
   output logic                      holdover
);

   localparam int E  = ACC_W + 2;
   localparam int HW = (HELPER_DIV > 1) ? $clog2(HELPER_DIV) : 1;
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int SW = $clog2(TIMEOUT + 1);

   localparam logic signed [E-1:0] POS_MAX = $signed({{(E-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}});
   localparam logic signed [E-1:0] NEG_MIN = $signed({{(E-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}});
   localparam logic signed [E-1:0] FCW_MIN = E'(1);
   localparam logic signed [E-1:0] TOL_P   = E'(LOCK_TOL);
   localparam logic signed [E-1:0] TOL_N   = -TOL_P;

   typedef enum logic [1:0] {
      ACQ  = 2'd0,
      LOCK = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [HW-1:0]            hcnt_q;
   logic [ACC_W-1:0]         acc_q;
   logic signed [ACC_W-1:0]  integ_q, integ_d;
   logic [GW-1:0]            good_q, good_d;
   logic [SW-1:0]            sil_q, sil_d;
   logic [ACC_W-1:0]         fcw_d;
   logic                     primed_q;

   logic signed [E-1:0]      err_ext, p_term, i_term;
   logic signed [E-1:0]      integ_ext, integ_new_ext, nom_ext;
   logic signed [ACC_W-1:0]  integ_new;
   logic [ACC_W-1:0]         fcw_track, fcw_hold, fcw_init;
   logic                     err_small;

   function automatic logic signed [ACC_W-1:0] sat_int(input logic signed [E-1:0] v);
      if (v > POS_MAX)      return POS_MAX[ACC_W-1:0];
      else if (v < NEG_MIN) return NEG_MIN[ACC_W-1:0];
      else                  return v[ACC_W-1:0];
   endfunction

   function automatic logic [ACC_W-1:0] clamp_fcw(input logic signed [E-1:0] v);
      if (v < FCW_MIN)      return FCW_MIN[ACC_W-1:0];
      else if (v > POS_MAX) return POS_MAX[ACC_W-1:0];
      else                  return v[ACC_W-1:0];
   endfunction

   // Two guard bits keep the most negative error and the shifted gains from wrapping.
   assign err_ext       = {{(E-COUNT_W){phase_err_beat[COUNT_W-1]}}, phase_err_beat};
   assign p_term        = err_ext <<< KP_SHIFT;
   assign i_term        = err_ext <<< KI_SHIFT;
   assign integ_ext     = {{2{integ_q[ACC_W-1]}}, integ_q};
   assign nom_ext       = $signed({2'b00, fcw_nom});
   assign integ_new     = sat_int(integ_ext + i_term);
   assign integ_new_ext = {{2{integ_new[ACC_W-1]}}, integ_new};
   assign fcw_track     = clamp_fcw(nom_ext + integ_new_ext + p_term);
   assign fcw_hold      = clamp_fcw(nom_ext + integ_ext);
   assign fcw_init      = clamp_fcw(nom_ext);
   assign err_small     = (err_ext <= TOL_P) && (err_ext >= TOL_N);

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      sil_d   = sil_q;
      integ_d = integ_q;
      fcw_d   = fcw_cur;
      if (phase_valid) begin
         integ_d = integ_new;
         fcw_d   = fcw_track;
         sil_d   = '0;
         if (state_q == LOCK) begin
            if (!err_small) begin
               state_d = ACQ;
               good_d  = '0;
            end
         end else begin
            // A valid arriving in HOLD is handled exactly like one in ACQ.
            state_d = ACQ;
            if (!err_small) begin
               good_d = '0;
            end else if (good_q == GW'(LOCK_CNT - 1)) begin
               state_d = LOCK;
               good_d  = '0;
            end else begin
               good_d = good_q + GW'(1);
            end
         end
      end else begin
         if (!primed_q) fcw_d = fcw_init;
         if (state_q != HOLD && helper_tick) begin
            if (sil_q == SW'(TIMEOUT - 1)) begin
               state_d = HOLD;
               sil_d   = '0;
               good_d  = '0;
            end else begin
               sil_d = sil_q + SW'(1);
            end
         end
         if (state_d == HOLD) fcw_d = fcw_hold;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACQ;
         hcnt_q      <= '0;
         acc_q       <= '0;
         integ_q     <= '0;
         good_q      <= '0;
         sil_q       <= '0;
         primed_q    <= 1'b0;
         helper_tick <= 1'b0;
         clk_fb_out  <= 1'b0;
         fcw_cur     <= '0;
      end else if (ena) begin
         if (hcnt_q == HW'(HELPER_DIV - 1)) begin
            hcnt_q      <= '0;
            helper_tick <= 1'b1;
         end else begin
            hcnt_q      <= hcnt_q + HW'(1);
            helper_tick <= 1'b0;
         end
         acc_q      <= acc_q + fcw_cur;
         clk_fb_out <= acc_q[ACC_W-1];
         state_q    <= state_d;
         integ_q    <= integ_d;
         good_q     <= good_d;
         sil_q      <= sil_d;
         fcw_cur    <= fcw_d;
         primed_q   <= 1'b1;
      end else begin
         helper_tick <= 1'b0;
      end
   end

   assign locked   = (state_q == LOCK);
   assign holdover = (state_q == HOLD);

endmodule

// File: tb/tb_ddmtd_dco.sv
// tb/tb_ddmtd_dco.sv - randomized bench for ddmtd_dco against a cycle-level behavioural model
module tb_ddmtd_dco;

   localparam longint ACC_MOD = 64'd16777216;
   localparam longint POS_MAX = 64'd8388607;
   localparam longint NEG_MIN = -64'd8388608;
   localparam int     DIV     = 10;
   localparam int     TMO     = 4;
   localparam int     LCNT    = 8;
   localparam int     TOL     = 2;

   logic               clk_sys = 1'b0;
   logic               rst_n;
   logic               ena;
   logic [23:0]        fcw_nom;
   logic               phase_valid;
   logic signed [15:0] phase_err_beat;
   logic               helper_tick, clk_fb_out, locked, holdover;
   logic [23:0]        fcw_cur;

   ddmtd_dco #(
      .COUNT_W(16), .ACC_W(24), .KP_SHIFT(4), .KI_SHIFT(0), .HELPER_DIV(DIV),
      .LOCK_TOL(TOL), .LOCK_CNT(LCNT), .TIMEOUT(TMO)
   ) dut (
      .clk_sys(clk_sys), .rst_n(rst_n), .ena(ena), .fcw_nom(fcw_nom),
      .phase_valid(phase_valid), .phase_err_beat(phase_err_beat),
      .helper_tick(helper_tick), .clk_fb_out(clk_fb_out), .fcw_cur(fcw_cur),
      .locked(locked), .holdover(holdover)
   );

   always #5 clk_sys = ~clk_sys;

   int n_tests = 0;
   int n_fail  = 0;

   // model state: 0 = acquiring, 1 = locked, 2 = holdover
   longint m_integ, m_fcw, m_acc;
   int     m_st, m_good, m_sil, m_nen;
   bit     m_tick, m_fb, m_primed;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic longint clampf(input longint v);
      if (v < 1) return 1;
      if (v > POS_MAX) return POS_MAX;
      return v;
   endfunction

   function automatic longint abs64(input longint v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic model_reset();
      m_integ = 0; m_fcw = 0; m_acc = 0; m_st = 0; m_good = 0; m_sil = 0;
      m_nen = 0; m_tick = 0; m_fb = 0; m_primed = 0;
   endtask

   task automatic model_step(input bit e, input bit v, input longint er, input longint nom);
      bit old_tick;
      if (!e) begin
         m_tick = 0;
         return;
      end
      old_tick = m_tick;
      m_nen++;
      m_tick = ((m_nen % DIV) == 0);
      m_fb   = ((m_acc >> 23) & 1) != 0;
      m_acc  = (m_acc + m_fcw) % ACC_MOD;
      if (v) begin
         m_integ = m_integ + er;
         if (m_integ > POS_MAX) m_integ = POS_MAX;
         if (m_integ < NEG_MIN) m_integ = NEG_MIN;
         m_fcw = clampf(nom + m_integ + er * 16);
         m_sil = 0;
         if (m_st == 1) begin
            if (abs64(er) > TOL) begin m_st = 0; m_good = 0; end
         end else begin
            m_st = 0;
            if (abs64(er) <= TOL) m_good++; else m_good = 0;
            if (m_good == LCNT) begin m_st = 1; m_good = 0; end
         end
      end else begin
         if (!m_primed) m_fcw = clampf(nom);
         if (m_st != 2 && old_tick) begin
            m_sil++;
            if (m_sil == TMO) begin m_st = 2; m_sil = 0; m_good = 0; end
         end
         if (m_st == 2) m_fcw = clampf(nom + m_integ);
      end
      m_primed = 1;
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".tick"}, 64'(helper_tick), 64'(m_tick));
      check({tag, ".fb"}, 64'(clk_fb_out), 64'(m_fb));
      check({tag, ".fcw"}, 64'(fcw_cur), 64'(m_fcw));
      check({tag, ".locked"}, 64'(locked), 64'(m_st == 1));
      check({tag, ".hold"}, 64'(holdover), 64'(m_st == 2));
   endtask

   task automatic step(input string tag, input bit e, input bit v, input logic signed [15:0] er);
      longint le;
      le = er;
      ena = e; phase_valid = v; phase_err_beat = er;
      @(posedge clk_sys);
      model_step(e, v, le, longint'(fcw_nom));
      #1;
      compare_all(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; ena = 1'b0; phase_valid = 1'b0; phase_err_beat = '0;
      repeat (2) @(posedge clk_sys);
      #1;
      model_reset();
      compare_all("reset");
      rst_n = 1'b1;
   endtask

   function automatic logic signed [15:0] rand_err();
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5)      return 16'(int'($urandom_range(0, 6)) - 3);
      else if (r < 8) return 16'(int'($urandom_range(0, 400)) - 200);
      else            return 16'($urandom);
   endfunction

   initial begin
      int ticks, highs;
      fcw_nom = 24'h100000;
      do_reset();

      // helper tick cadence and enable stall; feedback clock at nominal FCW
      ticks = 0; highs = 0;
      for (int c = 1; c <= 30; c++) begin
         step("cad", 1'b1, 1'b0, '0);
         if (helper_tick) ticks++;
         if (c == 10 || c == 20 || c == 30) check("tick_at_n0", 64'(helper_tick), 64'd1);
      end
      check("tick_count", 64'(ticks), 64'd3);
      repeat (5) step("stall", 1'b0, 1'b1, 16'sd100);
      for (int c = 36; c <= 45; c++) begin
         step("cad2", 1'b1, 1'b0, '0);
         if (c == 40) check("tick_40", 64'(helper_tick), 64'd0);
         if (c == 45) check("tick_45", 64'(helper_tick), 64'd1);
      end
      for (int c = 0; c < 32; c++) begin
         step("fb", 1'b1, 1'b0, '0);
         if (clk_fb_out) highs++;
      end
      check("fb_duty", 64'(highs), 64'd16);

      // proportional / integral steps
      do_reset();
      step("prime", 1'b1, 1'b0, '0);
      check("prime_fcw", 64'(fcw_cur), 64'h100000);
      step("p3", 1'b1, 1'b1, 16'sd3);
      check("fcw_p3", 64'(fcw_cur), 64'h100033);
      step("m3", 1'b1, 1'b1, -16'sd3);
      check("fcw_m3", 64'(fcw_cur), 64'h0FFFD0);

      // lock acquisition and loss
      for (int k = 0; k < LCNT; k++) begin
         step("acq", 1'b1, 1'b1, 16'(int'($urandom_range(0, 4)) - 2));
         if (k == LCNT - 2) check("not_yet_locked", 64'(locked), 64'd0);
      end
      check("locked_after_8", 64'(locked), 64'd1);
      step("lose", 1'b1, 1'b1, 16'sd5);
      check("lock_lost", 64'(locked), 64'd0);

      // saturation both ways, including the most negative error
      for (int k = 0; k < 300; k++) step("satp", 1'b1, 1'b1, 16'sh7FFF);
      check("fcw_sat_hi", 64'(fcw_cur), 64'h7FFFFF);
      for (int k = 0; k < 300; k++) step("satn", 1'b1, 1'b1, -16'sd32768);
      check("fcw_sat_lo", 64'(fcw_cur), 64'd1);

      // holdover entry and exit
      do_reset();
      step("prime2", 1'b1, 1'b0, '0);
      step("h3", 1'b1, 1'b1, 16'sd3);
      for (int k = 0; k < 50; k++) step("sil", 1'b1, 1'b0, '0);
      check("hold_on", 64'(holdover), 64'd1);
      check("hold_fcw", 64'(fcw_cur), 64'h100003);
      step("h0", 1'b1, 1'b1, 16'sd0);
      check("hold_off", 64'(holdover), 64'd0);
      check("hold_exit_fcw", 64'(fcw_cur), 64'h100003);

      // randomized operation with asynchronous mid-run resets
      for (int ph = 0; ph < 4; ph++) begin
         int vprob;
         vprob = (ph % 2 == 0) ? 25 : 2;
         for (int c = 0; c < 700; c++) begin
            if ($urandom_range(0, 99) == 0) fcw_nom = 24'(32'h80000 + $urandom_range(0, 32'h180000));
            step("rnd", ($urandom_range(0, 9) != 0), (int'($urandom_range(0, 99)) < vprob), rand_err());
         end
         #2 rst_n = 1'b0;
         #1;
         check("arst.tick", 64'(helper_tick), 64'd0);
         check("arst.fb", 64'(clk_fb_out), 64'd0);
         check("arst.fcw", 64'(fcw_cur), 64'd0);
         check("arst.locked", 64'(locked), 64'd0);
         check("arst.hold", 64'(holdover), 64'd0);
         do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
